seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with frame snapshot and blink.
// Ports: CLK, RESETN, IN_* page data/mask -> OUT_SEG, OUT_COM, OUT_FRAME.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 1000,
  parameter int DEAD_CYC  = 2,
  parameter int BLINK_DIV = 500000,
  parameter int SEG_INV   = 0,
  parameter int COM_INV   = 1
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [1:0]  IN_PAGE_SEL,
  input  logic [16:0] IN_TIME,
  input  logic [15:0] IN_DATE,
  input  logic [16:0] IN_ALARM_TIME,
  input  logic [2:0]  IN_BLINK_MASK,
  output logic [7:0]  OUT_SEG,
  output logic [5:0]  OUT_COM,
  output logic        OUT_FRAME
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SC_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEAD_LIM = SW'(DEAD_CYC);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);
  localparam logic [7:0] SEG_X = (SEG_INV != 0) ? 8'hFF : 8'h00;
  localparam logic [5:0] COM_X = (COM_INV != 0) ? 6'h3F : 6'h00;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [1:0]    page_q, page_d;
  logic [16:0]   time_q, time_d;
  logic [15:0]   date_q, date_d;
  logic [16:0]   alarm_q, alarm_d;
  logic [2:0]    mask_q, mask_d;
  logic [7:0]    out_seg_q, out_seg_d;
  logic [5:0]    out_com_q, out_com_d;
  logic          out_frame_q, out_frame_d;

  logic          scan_last;
  logic          bl_last;
  logic          wrap;
  logic [6:0]    hi, mid, lo, fld, digit;
  logic          mbit;
  logic [7:0]    seg;
  logic [5:0]    com;

  function automatic logic [6:0] lut(input logic [6:0] d);
    logic [6:0] r;
    r = 7'h00;
    case (d)
      7'd0: r = 7'h3F;
      7'd1: r = 7'h06;
      7'd2: r = 7'h5B;
      7'd3: r = 7'h4F;
      7'd4: r = 7'h66;
      7'd5: r = 7'h6D;
      7'd6: r = 7'h7D;
      7'd7: r = 7'h07;
      7'd8: r = 7'h7F;
      7'd9: r = 7'h6F;
      default: r = 7'h00;
    endcase
    return r;
  endfunction

  // Timebase and frame snapshot
  always_comb begin
    scan_last   = (scan_cnt_q == SC_LAST);
    wrap        = scan_last && (idx_q == 3'd5);
    scan_cnt_d  = scan_last ? '0 : scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    if (scan_last) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    bl_last     = (blink_cnt_q == BL_LAST);
    blink_cnt_d = bl_last ? '0 : blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q ^ bl_last;
    page_d      = wrap ? IN_PAGE_SEL   : page_q;
    time_d      = wrap ? IN_TIME       : time_q;
    date_d      = wrap ? IN_DATE       : date_q;
    alarm_d     = wrap ? IN_ALARM_TIME : alarm_q;
    mask_d      = wrap ? IN_BLINK_MASK : mask_q;
  end

  // Digit decode from the snapshot only
  always_comb begin
    hi  = '0;
    mid = '0;
    lo  = '0;
    case (page_q)
      2'd0: begin
        hi  = {2'b0, time_q[16:12]};
        mid = {1'b0, time_q[11:6]};
        lo  = {1'b0, time_q[5:0]};
      end
      2'd1: begin
        hi  = date_q[15:9];
        mid = {3'b0, date_q[8:5]};
        lo  = {2'b0, date_q[4:0]};
      end
      2'd2: begin
        hi  = {2'b0, alarm_q[16:12]};
        mid = {1'b0, alarm_q[11:6]};
        lo  = {1'b0, alarm_q[5:0]};
      end
      default: ;
    endcase
    case (idx_q)
      3'd0, 3'd1: begin fld = hi;  mbit = mask_q[2]; end
      3'd2, 3'd3: begin fld = mid; mbit = mask_q[1]; end
      default:    begin fld = lo;  mbit = mask_q[0]; end
    endcase
    digit = idx_q[0] ? (fld % 7'd10) : (fld / 7'd10);
    seg   = (fld > 7'd99) ? 8'h40 : {1'b0, lut(digit)};
    if (page_q == 2'd1 && (idx_q == 3'd1 || idx_q == 3'd3)) seg[7] = 1'b1;
    if (page_q == 2'd3 || (blink_ph_q && mbit)) seg = 8'h00;
    com = (scan_cnt_q < DEAD_LIM) ? 6'h00 : (6'b1 << idx_q);
    // Inversion is applied last, after blanking and dp
    out_seg_d   = seg ^ SEG_X;
    out_com_d   = com ^ COM_X;
    out_frame_d = wrap;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      page_q      <= '0;
      time_q      <= '0;
      date_q      <= '0;
      alarm_q     <= '0;
      mask_q      <= '0;
      out_seg_q   <= SEG_X;
      out_com_q   <= COM_X;
      out_frame_q <= 1'b0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      page_q      <= page_d;
      time_q      <= time_d;
      date_q      <= date_d;
      alarm_q     <= alarm_d;
      mask_q      <= mask_d;
      out_seg_q   <= out_seg_d;
      out_com_q   <= out_com_d;
      out_frame_q <= out_frame_d;
    end
  end

  assign OUT_SEG   = out_seg_q;
  assign OUT_COM   = out_com_q;
  assign OUT_FRAME = out_frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: time-indexed reference model plus
// directed vectors with hand-computed digit patterns.
module tb_seg_scan_driver;

  logic        CLK;
  logic        RESETN;
  logic [1:0]  IN_PAGE_SEL;
  logic [16:0] IN_TIME;
  logic [15:0] IN_DATE;
  logic [16:0] IN_ALARM_TIME;
  logic [2:0]  IN_BLINK_MASK;
  logic [7:0]  OUT_SEG;
  logic [5:0]  OUT_COM;
  logic        OUT_FRAME;

  seg_scan_driver #(
    .SCAN_DIV(4), .DEAD_CYC(1), .BLINK_DIV(16)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .IN_PAGE_SEL(IN_PAGE_SEL), .IN_TIME(IN_TIME),
    .IN_DATE(IN_DATE), .IN_ALARM_TIME(IN_ALARM_TIME),
    .IN_BLINK_MASK(IN_BLINK_MASK),
    .OUT_SEG(OUT_SEG), .OUT_COM(OUT_COM), .OUT_FRAME(OUT_FRAME)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  page;
    logic [16:0] tm;
    logic [15:0] dt;
    logic [16:0] al;
    logic [2:0]  mask;
  } snap_t;

  int    vectors = 0;
  int    errs = 0;
  int    k = 0;
  snap_t snaps [0:255];
  logic [7:0] lut [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                            8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [5:0] com_on [0:5] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [7:0] g [0:5];
  logic [5:0] gc [0:5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] tm(input int h, input int m, input int s);
    logic [4:0] hh;
    logic [5:0] mm, ss;
    hh = h[4:0];
    mm = m[5:0];
    ss = s[5:0];
    return {hh, mm, ss};
  endfunction

  // Expected segments from the display rules: field per digit pair,
  // decimal split, dash above 99, dp on date, blink and page 3 blanking.
  function automatic logic [7:0] exp_seg(input snap_t sn, input int d,
                                         input int ph);
    int v;
    int f;
    logic [7:0] r;
    f = d / 2;
    v = 0;
    if (sn.page == 2'd0 || sn.page == 2'd2) begin
      logic [16:0] t;
      t = (sn.page == 2'd0) ? sn.tm : sn.al;
      if (f == 0) v = int'(t[16:12]);
      else if (f == 1) v = int'(t[11:6]);
      else v = int'(t[5:0]);
    end else if (sn.page == 2'd1) begin
      if (f == 0) v = int'(sn.dt[15:9]);
      else if (f == 1) v = int'(sn.dt[8:5]);
      else v = int'(sn.dt[4:0]);
    end
    if (v > 99) r = 8'h40;
    else r = lut[(d % 2 == 1) ? v % 10 : v / 10];
    if (sn.page == 2'd1 && (d == 1 || d == 3)) r[7] = 1'b1;
    if (sn.page == 2'd3) r = 8'h00;
    if (ph == 1 && sn.mask[2 - f]) r = 8'h00;
    return r;
  endfunction

  // k = clock edges since reset release; frame n uses inputs seen at edge 24n
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      k = 0;
      snaps[0] = '0;
    end else begin
      k++;
      if (k % 24 == 0 && k / 24 < 256)
        snaps[k / 24] = '{IN_PAGE_SEL, IN_TIME, IN_DATE,
                          IN_ALARM_TIME, IN_BLINK_MASK};
    end
  end

  always @(negedge CLK) begin
    if (!RESETN || k == 0) begin
      chk("m_rst_com", 32'(OUT_COM), 32'h3F);
      chk("m_rst_seg", 32'(OUT_SEG), 32'h00);
      chk("m_rst_frame", 32'(OUT_FRAME), 32'h0);
    end else begin
      int j, s, d, f, ph;
      j  = k - 1;
      s  = j % 4;
      d  = (j / 4) % 6;
      f  = j / 24;
      ph = (j / 16) % 2;
      chk("m_com", 32'(OUT_COM), (s < 1) ? 32'h3F : 32'(com_on[d]));
      chk("m_frame", 32'(OUT_FRAME), (k % 24 == 0) ? 32'h1 : 32'h0);
      if (s >= 1 && f < 256)
        chk("m_seg", 32'(OUT_SEG), 32'(exp_seg(snaps[f], d, ph)));
    end
  end

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (OUT_FRAME !== 1'b1 && n < 40);
    chk("frame_seen", 32'(OUT_FRAME), 32'h1);
  endtask

  // Call at a frame-start sample; grabs one active sample per digit
  task automatic grab();
    for (int d = 0; d < 6; d++) begin
      repeat ((d == 0) ? 2 : 4) @(negedge CLK);
      g[d]  = OUT_SEG;
      gc[d] = OUT_COM;
    end
  endtask

  task automatic chk_frame(input string nm, input logic [47:0] exp);
    logic [47:0] e;
    e = exp;
    for (int d = 0; d < 6; d++) begin
      chk($sformatf("%s_d%0d", nm, d), 32'(g[d]), 32'(e[47 - 8*d -: 8]));
      chk($sformatf("%s_c%0d", nm, d), 32'(gc[d]), 32'(com_on[d]));
    end
  endtask

  initial begin
    int n;
    int on_seen, off_seen;
    RESETN = 1'b0;
    IN_PAGE_SEL = 2'd0;
    IN_TIME = tm(12, 34, 56);
    IN_DATE = 16'h0;
    IN_ALARM_TIME = 17'h0;
    IN_BLINK_MASK = 3'b000;
    repeat (3) @(negedge CLK);
    chk("rst_com", 32'(OUT_COM), 32'h3F);
    chk("rst_seg", 32'(OUT_SEG), 32'h00);
    chk("rst_frame", 32'(OUT_FRAME), 32'h0);
    RESETN = 1'b1;

    grab();
    chk_frame("boot", 48'h3F3F3F3F3F3F);
    wait_frame(n);
    chk("first_frame_cyc", 32'(22 + n), 32'd24);
    grab();
    chk_frame("time", 48'h065B4F666D7D);
    wait_frame(n);
    wait_frame(n);
    chk("frame_period", 32'(n), 32'd24);

    @(negedge CLK);
    IN_PAGE_SEL = 2'd1;
    IN_DATE = {7'd125, 4'd7, 5'd3};
    wait_frame(n);
    grab();
    chk_frame("date", 48'h40C03F873F4F);

    IN_PAGE_SEL = 2'd2;
    IN_ALARM_TIME = tm(7, 30, 0);
    IN_BLINK_MASK = 3'b010;
    wait_frame(n);
    on_seen = 0;
    off_seen = 0;
    for (int i = 0; i < 4; i++) begin
      grab();
      chk("al_d0", 32'(g[0]), 32'h3F);
      chk("al_d1", 32'(g[1]), 32'h07);
      chk("al_d2", 32'(g[2] == 8'h4F || g[2] == 8'h00), 32'h1);
      chk("al_d3", 32'(g[3] == 8'h3F || g[3] == 8'h00), 32'h1);
      chk("al_d4", 32'(g[4]), 32'h3F);
      chk("al_d5", 32'(g[5]), 32'h3F);
      if (g[2] == 8'h4F) on_seen++;
      if (g[2] == 8'h00) off_seen++;
      wait_frame(n);
    end
    chk("blink_both", 32'(on_seen > 0 && off_seen > 0), 32'h1);

    IN_PAGE_SEL = 2'd0;
    IN_TIME = tm(12, 34, 56);
    IN_BLINK_MASK = 3'b000;
    wait_frame(n);
    repeat (2 + 4 * 3) @(negedge CLK);
    chk("tear_d3a", 32'(OUT_SEG), 32'h66);
    IN_TIME = tm(23, 59, 48);
    @(negedge CLK);
    chk("tear_d3b", 32'(OUT_SEG), 32'h66);
    repeat (4) @(negedge CLK);
    chk("tear_d4", 32'(OUT_SEG), 32'h6D);
    repeat (4) @(negedge CLK);
    chk("tear_d5", 32'(OUT_SEG), 32'h7D);
    wait_frame(n);
    grab();
    chk_frame("newtime", 48'h5B4F6D6F667F);

    wait_frame(n);
    repeat (9) @(negedge CLK);
    @(posedge CLK);
    #2 RESETN = 1'b0;
    #1;
    chk("async_com", 32'(OUT_COM), 32'h3F);
    chk("async_seg", 32'(OUT_SEG), 32'h00);
    chk("async_frame", 32'(OUT_FRAME), 32'h0);
    #1 RESETN = 1'b1;
    @(negedge CLK);
    grab();
    chk_frame("reboot", 48'h3F3F3F3F3F3F);
    wait_frame(n);
    chk("refirst_cyc", 32'(22 + n), 32'd24);
    grab();
    chk_frame("reboot2", 48'h5B4F6D6F667F);

    IN_PAGE_SEL = 2'd3;
    wait_frame(n);
    grab();
    chk_frame("blank", 48'h000000000000);
    wait_frame(n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
